matrix_frame_scheduler: RTL and testbench
=========================================

Name: matrix_frame_scheduler

Overview:
Sequences the 8x8 LED matrix strip serializer: issues one frame request per refresh tick, waits for frame completion, and steps the displayed glyph index through the font table after a programmable number of frames. Supplies the foreground and background 32-bit LED words the serializer emits for lit and unlit pixels. Sits between the top-level io pins and the serializer; the serializer owns the bit-level strip output.

Parameters:
GLYPHS, 26, number of glyphs in the font table; glyph_idx wraps at GLYPHS-1 (2..32)
HOLD_FRAMES, 16, frames each glyph is shown before advancing (>=1)
TICK_DIV, 2000, clk cycles per refresh tick (>=2)
TIMEOUT, 8192, max clk cycles in BUSY before aborting the frame
FG_WORD, 32'hF00F0000, LED word for lit pixels
BG_WORD, 32'hF0000000, LED word for unlit pixels

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
enable  in  1  level; 1 = run refresh sequence
pause  in  1  level; 1 = keep refreshing but freeze glyph advance
step  in  1  single-cycle pulse; force advance at next ADVANCE
frame_start  out  1  single-cycle pulse requesting one serializer frame
frame_done  in  1  single-cycle pulse from serializer, end frame sent
glyph_idx  out  5  current glyph index
fg_word  out  32  LED word for lit pixels
bg_word  out  32  LED word for unlit pixels
busy  out  1  1 while in START or BUSY
overrun  out  1  sticky: tick arrived outside WAIT_TICK
timeout_err  out  1  sticky: frame_done not seen within TIMEOUT

Behaviour:
- Reset (async, immediate): state IDLE, glyph_idx=0, hold count=0, tick count=0, step latch=0, frame_start=0, busy=0, overrun=0, timeout_err=0; fg_word=FG_WORD, bg_word=BG_WORD. Reset mid-frame aborts with no further pulse.
- Tick counter: runs 0..TICK_DIV-1 while enable=1, cleared while enable=0; tick = count==TICK_DIV-1 (one cycle per TICK_DIV).
- States: IDLE, WAIT_TICK, START, BUSY, ADVANCE.
- IDLE: enable=1 -> WAIT_TICK next cycle.
- WAIT_TICK: enable=0 -> IDLE; tick -> START.
- START: frame_start=1 for exactly this one cycle; -> BUSY. busy=1.
- BUSY: busy=1; frame_done -> ADVANCE; frame_done in START is ignored. Timeout counter clears on entry; reaching TIMEOUT-1 without frame_done sets timeout_err, -> ADVANCE without glyph advance (hold count unchanged).
- ADVANCE (one cycle): if step latch set, or (pause=0 and hold==HOLD_FRAMES-1): hold=0, glyph_idx = (glyph_idx==GLYPHS-1) ? 0 : glyph_idx+1, step latch cleared. Else if pause=0: hold+1. Pause=1 without step: no change. Then -> WAIT_TICK if enable=1 else IDLE.
- enable dropped in START/BUSY: current frame completes (waits frame_done or timeout), then IDLE. No frame truncation.
- step pulse in any state sets step latch; latch consumed only in ADVANCE; multiple pulses before ADVANCE = one advance.
- tick while state != WAIT_TICK: tick dropped, overrun=1 (sticky until reset).
- frame_start-to-frame_start minimum spacing = TICK_DIV cycles.
- glyph_idx, fg_word, bg_word change only in ADVANCE or reset; stable for the entire frame.

Optional Feature:
FRAME_SCHED_BLINK_EN: when defined, fg_word outputs BG_WORD during frames where hold count bit 0 is 1 (glyph blinks at half frame rate, updated in ADVANCE); bg_word unaffected. When undefined, fg_word is constant FG_WORD.

Test Plan:
- TICK_DIV=4, HOLD_FRAMES=2, GLYPHS=3, enable=1, frame_done 2 cycles after each frame_start -> frame_start every 4 cycles; glyph_idx 0,0,1,1,2,2,0 per frame pair; overrun=0.
- Same params, frame_done delayed 6 cycles -> overrun=1 after first frame; frame_start still single-cycle, glyph advance unchanged.
- TIMEOUT=8, frame_done never asserted -> timeout_err=1 8 cycles after frame_start; glyph_idx stays 0; next frame_start on following tick.
- pause=1 for 4 frames with step pulsed twice during one frame -> glyph_idx advances exactly once, at that frame's ADVANCE.
- enable deasserted 1 cycle after frame_start -> no further frame_start after frame_done; state IDLE, busy=0; reset asserted mid-BUSY -> all outputs return to reset values immediately.
- With FRAME_SCHED_BLINK_EN, HOLD_FRAMES=4 -> fg_word sequence F00F0000, F0000000, F00F0000, F0000000 across frames.

Source files
------------

// File: rtl/matrix_frame_scheduler.sv
// Frame refresh sequencer for the 8x8 LED matrix serializer: one frame request per tick,
// glyph stepping after HOLD_FRAMES frames. Define FRAME_SCHED_BLINK_EN to blink fg_word.
module matrix_frame_scheduler #(
  parameter int unsigned GLYPHS      = 26,
  parameter int unsigned HOLD_FRAMES = 16,
  parameter int unsigned TICK_DIV    = 2000,
  parameter int unsigned TIMEOUT     = 8192,
  parameter logic [31:0] FG_WORD     = 32'hF00F0000,
  parameter logic [31:0] BG_WORD     = 32'hF0000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pause,
  input  logic        step,
  output logic        frame_start,
  input  logic        frame_done,
  output logic [4:0]  glyph_idx,
  output logic [31:0] fg_word,
  output logic [31:0] bg_word,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned OW = $clog2(TIMEOUT);
  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] TO_LAST    = OW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
  localparam logic [4:0]    GLYPH_LAST = 5'(GLYPHS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_BUSY,
    S_ADVANCE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_tick_cnt;
  logic [OW-1:0] r_to_cnt;
  logic [HW-1:0] r_hold;
  logic [4:0]    r_glyph;
  logic          r_step;
  logic          r_abort;
  logic          r_overrun;
  logic          r_timeout;

  logic          w_tick;
  logic          w_to_expire;
  logic          w_step_any;
  logic          w_take;
  logic [HW-1:0] w_hold_nxt;
  logic [4:0]    w_glyph_nxt;

  assign w_tick      = enable && (r_tick_cnt == TICK_LAST);
  assign w_to_expire = (r_state == S_BUSY) && !frame_done && (r_to_cnt == TO_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (enable) w_next = S_WAIT_TICK;
      S_WAIT_TICK: begin
        if (!enable)     w_next = S_IDLE;
        else if (w_tick) w_next = S_START;
      end
      S_START:     w_next = S_BUSY;
      S_BUSY:      if (frame_done || w_to_expire) w_next = S_ADVANCE;
      S_ADVANCE:   w_next = enable ? S_WAIT_TICK : S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    frame_start = (r_state == S_START);
    busy        = (r_state == S_START) || (r_state == S_BUSY);
  end

  // Aborted frames reach ADVANCE without touching hold, glyph or the step latch
  always_comb begin
    w_step_any  = r_step | step;
    w_take      = 1'b0;
    w_hold_nxt  = r_hold;
    w_glyph_nxt = r_glyph;
    if (r_state == S_ADVANCE && !r_abort) begin
      if (w_step_any || (!pause && r_hold == HOLD_LAST)) begin
        w_take      = 1'b1;
        w_hold_nxt  = '0;
        w_glyph_nxt = (r_glyph == GLYPH_LAST) ? '0 : r_glyph + 5'd1;
      end else if (!pause) begin
        w_hold_nxt = r_hold + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_to_cnt   <= '0;
      r_hold     <= '0;
      r_glyph    <= '0;
      r_step     <= 1'b0;
      r_abort    <= 1'b0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (!enable || r_tick_cnt == TICK_LAST) r_tick_cnt <= '0;
      else                                    r_tick_cnt <= r_tick_cnt + TW'(1);

      if (r_state == S_BUSY) r_to_cnt <= r_to_cnt + OW'(1);
      else                   r_to_cnt <= '0;

      r_abort <= w_to_expire;
      r_hold  <= w_hold_nxt;
      r_glyph <= w_glyph_nxt;

      if (w_take)    r_step <= 1'b0;
      else if (step) r_step <= 1'b1;

      if (w_tick && r_state != S_WAIT_TICK) r_overrun <= 1'b1;
      if (w_to_expire)                      r_timeout <= 1'b1;
    end
  end

`ifdef FRAME_SCHED_BLINK_EN
  logic [31:0] r_fg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_fg <= FG_WORD;
    else if (r_state == S_ADVANCE) r_fg <= w_hold_nxt[0] ? BG_WORD : FG_WORD;
  end
  assign fg_word = r_fg;
`else
  assign fg_word = FG_WORD;
`endif

  assign bg_word     = BG_WORD;
  assign glyph_idx   = r_glyph;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Directed bench for matrix_frame_scheduler: TICK_DIV=4, HOLD_FRAMES=2, GLYPHS=3, TIMEOUT=8.
module tb_matrix_frame_scheduler;

  localparam logic [31:0] FG = 32'hF00F0000;
  localparam logic [31:0] BG = 32'hF0000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pause = 1'b0;
  logic        step = 1'b0;
  logic        frame_done = 1'b0;
  logic        frame_start;
  logic [4:0]  glyph_idx;
  logic [31:0] fg_word;
  logic [31:0] bg_word;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_frame_scheduler #(
    .GLYPHS(3),
    .HOLD_FRAMES(2),
    .TICK_DIV(4),
    .TIMEOUT(8),
    .FG_WORD(32'hF00F0000),
    .BG_WORD(32'hF0000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pause(pause),
    .step(step),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .glyph_idx(glyph_idx),
    .fg_word(fg_word),
    .bg_word(bg_word),
    .busy(busy),
    .overrun(overrun),
    .timeout_err(timeout_err)
  );

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; pause = 1'b0; step = 1'b0; frame_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Returns at the negedge where frame_start is seen high; an expired bound counts as a failure.
  task automatic wait_fs(output logic found);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL wait_frame_start: got none within 100 cycles, want a pulse");
    end
  endtask

  // Called at the negedge of the frame_start cycle c; frame_done is high during cycle c+d-1.
  task automatic do_frame(input int d);
    repeat (d - 1) @(posedge clk);
    #1 frame_done = 1'b1;
    @(posedge clk);
    #1 frame_done = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    do_reset();
    @(negedge clk);
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (glyph_idx !== 5'd0) begin bad++; $display("FAIL rst_glyph: got %0d want 0", glyph_idx); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout_err); end
    total++; if (fg_word !== FG) begin bad++; $display("FAIL rst_fg: got %h want %h", fg_word, FG); end
    total++; if (bg_word !== BG) begin bad++; $display("FAIL rst_bg: got %h want %h", bg_word, BG); end
    pulses = 0;
    repeat (12) begin @(negedge clk); if (frame_start === 1'b1) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL disabled_no_frames: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_glyph_sequence();
    int exp_g[7] = '{0, 0, 1, 1, 2, 2, 0};
    logic found;
    logic [31:0] exp_fg;
    int prev;
    do_reset();
    enable = 1'b1;
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      wait_fs(found);
      if (!found) return;
      total++; if (glyph_idx !== 5'(exp_g[i])) begin bad++; $display("FAIL glyph_seq[%0d]: got %0d want %0d", i, glyph_idx, exp_g[i]); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_start[%0d]: got %b want 1", i, busy); end
`ifdef FRAME_SCHED_BLINK_EN
      exp_fg = (i % 2 == 1) ? BG : FG;
`else
      exp_fg = FG;
`endif
      total++; if (fg_word !== exp_fg) begin bad++; $display("FAIL fg_seq[%0d]: got %h want %h", i, fg_word, exp_fg); end
      if (i > 0) begin
        total++; if (cyc - prev != 4) begin bad++; $display("FAIL fs_spacing[%0d]: got %0d want 4", i, cyc - prev); end
      end
      prev = cyc;
      do_frame(2);
    end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL seq_overrun: got %b want 0", overrun); end
    enable = 1'b0;
  endtask

  task automatic test_overrun();
    int exp_g[4] = '{0, 0, 1, 1};
    logic found;
    int prev;
    do_reset();
    enable = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_fs(found);
      if (!found) return;
      total++; if (glyph_idx !== 5'(exp_g[i])) begin bad++; $display("FAIL ovr_glyph[%0d]: got %0d want %0d", i, glyph_idx, exp_g[i]); end
      if (i > 0) begin
        total++; if (cyc - prev != 8) begin bad++; $display("FAIL ovr_spacing[%0d]: got %0d want 8", i, cyc - prev); end
      end
      prev = cyc;
      @(negedge clk);
      total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL ovr_fs_width[%0d]: got %b want 0", i, frame_start); end
      if (i == 0) begin
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early: got %b want 0", overrun); end
      end
      repeat (4) @(posedge clk);
      #1 frame_done = 1'b1;
      @(posedge clk);
      #1 frame_done = 1'b0;
      if (i == 0) begin
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_timeout();
    logic found;
    int c0;
    do_reset();
    enable = 1'b1;
    wait_fs(found);
    if (!found) return;
    c0 = cyc;
    repeat (8) @(negedge clk);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", timeout_err); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy_last: got %b want 1", busy); end
    @(negedge clk);
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_set: got %b want 1", timeout_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy_after: got %b want 0", busy); end
    wait_fs(found);
    if (!found) return;
    total++; if (cyc - c0 != 12) begin bad++; $display("FAIL to_next_fs: got %0d want 12", cyc - c0); end
    total++; if (glyph_idx !== 5'd0) begin bad++; $display("FAIL to_glyph: got %0d want 0", glyph_idx); end
    enable = 1'b0;
  endtask

  task automatic test_pause_step();
    int exp_g[5] = '{0, 0, 1, 1, 1};
    logic found;
    do_reset();
    pause = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_fs(found);
      if (!found) return;
      total++; if (glyph_idx !== 5'(exp_g[i])) begin bad++; $display("FAIL pause_glyph[%0d]: got %0d want %0d", i, glyph_idx, exp_g[i]); end
      if (i == 1) begin
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0; frame_done = 1'b1;
        @(negedge clk);
        total++; if (glyph_idx !== 5'd0) begin bad++; $display("FAIL step_before_adv: got %0d want 0", glyph_idx); end
        @(posedge clk); #1 frame_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (glyph_idx !== 5'd1) begin bad++; $display("FAIL step_after_adv: got %0d want 1", glyph_idx); end
      end else begin
        do_frame(2);
      end
    end
    pause = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic found;
    int pulses;
    int busies;
    do_reset();
    enable = 1'b1;
    wait_fs(found);
    if (!found) return;
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy1: got %b want 1", busy); end
    @(posedge clk); #1 frame_done = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy2: got %b want 1", busy); end
    @(posedge clk); #1 frame_done = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy_adv: got %b want 0", busy); end
    pulses = 0;
    busies = 0;
    repeat (20) begin
      @(negedge clk);
      if (frame_start === 1'b1) pulses++;
      if (busy === 1'b1) busies++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL drop_no_frame: got %0d pulses want 0", pulses); end
    total++; if (busies != 0) begin bad++; $display("FAIL drop_idle_busy: got %0d busy cycles want 0", busies); end
  endtask

  task automatic test_reset_mid_busy();
    logic found;
    int pulses;
    do_reset();
    enable = 1'b1;
    wait_fs(found);
    if (!found) return;
    do_frame(6);
    wait_fs(found);
    if (!found) return;
    do_frame(2);
    wait_fs(found);
    if (!found) return;
    total++; if (glyph_idx !== 5'd1 || overrun !== 1'b1) begin
      bad++; $display("FAIL midrst_pre: got glyph=%0d ovr=%b want glyph=1 ovr=1", glyph_idx, overrun);
    end
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_pre: got %b want 1", busy); end
    #1 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL midrst_fs: got %b want 0", frame_start); end
    total++; if (glyph_idx !== 5'd0) begin bad++; $display("FAIL midrst_glyph: got %0d want 0", glyph_idx); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL midrst_timeout: got %b want 0", timeout_err); end
    total++; if (fg_word !== FG || bg_word !== BG) begin
      bad++; $display("FAIL midrst_words: got fg=%h bg=%h want fg=%h bg=%h", fg_word, bg_word, FG, BG);
    end
    pulses = 0;
    repeat (8) begin @(negedge clk); if (frame_start === 1'b1) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL midrst_no_pulse: got %0d pulses want 0", pulses); end
    enable = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glyph_sequence();
    test_overrun();
    test_timeout();
    test_pause_step();
    test_enable_drop();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
